enemy_attack_arbiter: RTL

ENEMY_ATTACK_ARBITER -- requirements
Module: enemy_attack_arbiter

---
 rtl/enemy_attack_arbiter_pkg.sv | 23 ++
 rtl/enemy_attack_arbiter_rr_pick.sv | 39 +++
 rtl/enemy_attack_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/enemy_attack_arbiter_pkg.sv
// Shared constants, state type and helpers for the enemy attack arbiter.
// Optional cooldown phase is enabled by defining ENEMY_ATTACK_ARB_COOLDOWN_EN.
package enemy_attack_arbiter_pkg;

  localparam int unsigned EnemyNumDefault       = 4;
  localparam int unsigned AttackFramesDefault   = 30;
  localparam int unsigned CooldownFramesDefault = 15;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StActive   = 2'd1,
    StCooldown = 2'd2
  } state_e;

  // One counter serves both phases, so size it for the longer of the two.
  function automatic int unsigned frame_cnt_width(input int unsigned attack_frames,
                                                  input int unsigned cooldown_frames);
    int unsigned max_frames;
    max_frames = (attack_frames > cooldown_frames) ? attack_frames : cooldown_frames;
    return $clog2(max_frames + 1);
  endfunction

endpackage

// File: rtl/enemy_attack_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after start_i.
module enemy_attack_arbiter_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] eligible_i,
  input  logic [2:0]   start_i,
  output logic [N-1:0] onehot_o,
  output logic [2:0]   idx_o,
  output logic         found_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [3:0]     sum;

  always_comb begin
    // Rotate so bit 0 of rot is the requester at start_i.
    dbl      = {eligible_i, eligible_i} >> start_i;
    rot      = dbl[N-1:0];
    sum      = '0;
    found_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    for (int j = 0; j < N; j++) begin
      if (!found_o && rot[j]) begin
        found_o = 1'b1;
        sum     = {1'b0, start_i} + 4'(j);
        if (sum >= 4'(N)) begin
          sum = sum - 4'(N);
        end
      end
    end
    if (found_o) begin
      idx_o    = sum[2:0];
      onehot_o = {{(N-1){1'b0}}, 1'b1} << sum;
    end
  end

endmodule

// File: rtl/enemy_attack_arbiter.sv
// Round-robin arbiter for the shared enemy attack slot; Grant feeds the attack enables and the
// attack ROM address mux. Define ENEMY_ATTACK_ARB_COOLDOWN_EN to add a cooldown after each attack.
module enemy_attack_arbiter
  import enemy_attack_arbiter_pkg::*;
#(
  parameter int unsigned ENEMY_NUM       = EnemyNumDefault,
  parameter int unsigned ATTACK_FRAMES   = AttackFramesDefault,
  parameter int unsigned COOLDOWN_FRAMES = CooldownFramesDefault
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 game_frame_clk_rising_edge,
  input  logic [ENEMY_NUM-1:0] Attack_Req,
  input  logic [ENEMY_NUM-1:0] Enemy_Alive,
  input  logic                 Abort,
  output logic [ENEMY_NUM-1:0] Grant,
  output logic [2:0]           Grant_Idx,
  output logic                 Grant_Valid,
  output logic                 Attack_Start
);

  localparam int unsigned CntW     = frame_cnt_width(ATTACK_FRAMES, COOLDOWN_FRAMES);
  localparam logic [2:0]  LastInit = 3'(ENEMY_NUM - 1);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             last_q, last_d;
  logic [ENEMY_NUM-1:0]   grant_q, grant_d;
  logic [2:0]             idx_q, idx_d;
  logic                   start_q, start_d;

  logic                   tick;
  logic                   rel;
  logic [2:0]             start_idx;
  logic [ENEMY_NUM-1:0]   eligible;
  logic [ENEMY_NUM-1:0]   pick_onehot;
  logic [2:0]             pick_idx;
  logic                   pick_found;

  assign tick      = game_frame_clk_rising_edge;
  assign eligible  = Attack_Req & Enemy_Alive;
  assign start_idx = (last_q == LastInit) ? 3'd0 : last_q + 3'd1;

  enemy_attack_arbiter_rr_pick #(
    .N (ENEMY_NUM)
  ) u_rr_pick (
    .eligible_i (eligible),
    .start_i    (start_idx),
    .onehot_o   (pick_onehot),
    .idx_o      (pick_idx),
    .found_o    (pick_found)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    start_d = 1'b0;
    rel     = 1'b0;
    if (Abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      grant_d = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (tick && pick_found) begin
            state_d = StActive;
            cnt_d   = CntW'(ATTACK_FRAMES);
            last_d  = pick_idx;
            grant_d = pick_onehot;
            idx_d   = pick_idx;
            start_d = 1'b1;
          end
        end
        StActive: begin
          // A dead holder releases at once; otherwise the last counted frame does.
          rel = ((grant_q & Enemy_Alive) == '0) || (tick && (cnt_q == CntW'(1)));
          if (tick) begin
            cnt_d = cnt_q - CntW'(1);
          end
          if (rel) begin
            grant_d = '0;
            idx_d   = '0;
`ifdef ENEMY_ATTACK_ARB_COOLDOWN_EN
            state_d = StCooldown;
            cnt_d   = CntW'(COOLDOWN_FRAMES);
`else
            state_d = StIdle;
            cnt_d   = '0;
`endif
          end
        end
        StCooldown: begin
          if (tick) begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          grant_d = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= LastInit;
      grant_q <= '0;
      idx_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      start_q <= start_d;
    end
  end

  assign Grant        = grant_q;
  assign Grant_Idx    = idx_q;
  assign Grant_Valid  = |grant_q;
  assign Attack_Start = start_q;

endmodule
